// File: rtl/led_chaser_pkg.sv
// Shared pattern/direction/phase encodings for the multi-pattern LED chaser.
// Latency: n/a (types only). Backpressure: n/a.
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'b00,
        MODE_SHR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } phase_e;

endpackage

// File: rtl/led_chaser_multi_prescaler.sv
// Programmable step prescaler: step is high on every (div+1)th enabled clki edge.
// Latency: step is combinational from the count; en=0 freezes the count (no step lost).
import led_chaser_pkg::*;

module tick_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clki,
    input  logic             rs,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so that shrinking div below the running count steps at once
    always_comb begin
        step  = en && (cnt_q >= div);
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clki) begin
        if (!rs) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser_multi.sv
// Multi-pattern LED chaser (shift-left/right, bounce, fill/drain) with step and wrap pulses.
// Latency: led/tick/wrap registered, updated one edge after the prescaler step; en=0 holds everything.
import led_chaser_pkg::*;

module led_chaser_multi #(
    parameter int N_LED = 8,
    parameter int DIV_W = 24
) (
    input  logic             clki,
    input  logic             rs,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [N_LED-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam logic [N_LED-1:0] LED_LO  = N_LED'(1);
    localparam logic [N_LED-1:0] LED_HI  = LED_LO << (N_LED - 1);
    localparam logic [N_LED-1:0] LED_ALL = '1;

    function automatic logic [N_LED-1:0] seed_of(input mode_e m);
        return (m == MODE_SHR) ? LED_HI : LED_LO;
    endfunction

    logic             step;
    mode_e            mode_in;
    logic             one_hot;
    mode_e            mode_q,  mode_d;
    logic [N_LED-1:0] led_q,   led_d;
    dir_e             dir_q,   dir_d;
    phase_e           phase_q, phase_d;
    logic             tick_q,  tick_d;
    logic             wrap_q,  wrap_d;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clki (clki),
        .rs   (rs),
        .en   (en),
        .div  (div),
        .step (step)
    );

    assign mode_in = mode_e'(mode);
    assign one_hot = (led_q != '0) && ((led_q & (led_q - LED_LO)) == '0);

    always_comb begin
        mode_d  = mode_q;
        led_d   = led_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        tick_d  = step;
        wrap_d  = 1'b0;
        if (step) begin
            if (mode_in != mode_q) begin
                mode_d  = mode_in;
                led_d   = seed_of(mode_in);
                dir_d   = DIR_UP;
                phase_d = PH_FILL;
            end else if (mode_q != MODE_FILL && !one_hot) begin
                // single-dot modes recover from any corrupted pattern
                led_d = seed_of(mode_q);
                dir_d = DIR_UP;
            end else begin
                case (mode_q)
                    MODE_SHL: begin
                        led_d  = {led_q[N_LED-2:0], led_q[N_LED-1]};
                        wrap_d = led_q[N_LED-1];
                    end
                    MODE_SHR: begin
                        led_d  = {led_q[0], led_q[N_LED-1:1]};
                        wrap_d = led_q[0];
                    end
                    MODE_BOUNCE: begin
                        if ((dir_q == DIR_UP && led_q[N_LED-1]) ||
                            (dir_q == DIR_DOWN && !led_q[0])) begin
                            dir_d  = DIR_DOWN;
                            led_d  = led_q >> 1;
                            wrap_d = ((led_q >> 1) == LED_LO);
                        end else begin
                            dir_d = DIR_UP;
                            led_d = led_q << 1;
                        end
                    end
                    MODE_FILL: begin
                        if (phase_q == PH_FILL) begin
                            led_d  = (led_q << 1) | LED_LO;
                            wrap_d = (led_q == '0);
                            if (((led_q << 1) | LED_LO) == LED_ALL) begin
                                phase_d = PH_DRAIN;
                            end
                        end else begin
                            led_d = led_q << 1;
                            if ((led_q << 1) == '0) begin
                                phase_d = PH_FILL;
                            end
                        end
                    end
                    default: begin
                        led_d = seed_of(mode_q);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clki) begin
        if (!rs) begin
            mode_q  <= MODE_SHL;
            led_q   <= LED_LO;
            dir_q   <= DIR_UP;
            phase_q <= PH_FILL;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_chaser_multi.sv
// Scoreboard bench for led_chaser_multi: a position-counter reference model predicts
// led/tick/wrap for every clock edge; predictions are queued and compared #1 after the edge.
module tb_led_chaser_multi;

    localparam int N  = 8;
    localparam int DW = 24;

    logic          clki = 1'b0;
    logic          rs   = 1'b0;
    logic          en   = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] div  = DW'(3);
    logic [N-1:0]  led;
    logic          tick;
    logic          wrap;

    typedef struct packed {
        logic [N-1:0] led;
        logic         tick;
        logic         wrap;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;

    // reference model: pattern is a pure function of (mode, position k)
    logic [DW-1:0] m_cnt  = '0;
    logic [1:0]    m_mode = 2'b00;
    int            m_k    = 0;
    logic          m_tick = 1'b0;
    logic          m_wrap = 1'b0;

    led_chaser_multi #(
        .N_LED (N),
        .DIV_W (DW)
    ) dut (
        .clki (clki),
        .rs   (rs),
        .en   (en),
        .mode (mode),
        .div  (div),
        .led  (led),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clki = ~clki;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic int period_of(input logic [1:0] m);
        case (m)
            2'b10:   return 2 * N - 2;
            2'b11:   return 2 * N;
            default: return N;
        endcase
    endfunction

    function automatic logic [N-1:0] model_led(input logic [1:0] m, input int k);
        logic [63:0] v;
        logic [63:0] all;
        all = (64'd1 << N) - 64'd1;
        case (m)
            2'b00:   v = 64'd1 << k;
            2'b01:   v = 64'd1 << (N - 1 - k);
            2'b10:   v = 64'd1 << ((k < N) ? k : (2 * N - 2 - k));
            default: v = (k < N) ? ((64'd1 << (k + 1)) - 64'd1) : ((all << (k - N + 1)) & all);
        endcase
        return v[N-1:0];
    endfunction

    task automatic model_edge();
        logic stp;
        if (!rs) begin
            m_cnt  = '0;
            m_mode = 2'b00;
            m_k    = 0;
            m_tick = 1'b0;
            m_wrap = 1'b0;
        end else begin
            stp    = en && (m_cnt >= div);
            m_tick = stp;
            m_wrap = 1'b0;
            if (en) m_cnt = stp ? '0 : m_cnt + DW'(1);
            if (stp) begin
                if (mode != m_mode) begin
                    m_mode = mode;
                    m_k    = 0;
                end else begin
                    m_k    = (m_k + 1) % period_of(m_mode);
                    m_wrap = (m_k == 0);
                end
            end
        end
    endtask

    task automatic step_cycle(input string tag);
        exp_t e;
        exp_t got;
        model_edge();
        e.led  = model_led(m_mode, m_k);
        e.tick = m_tick;
        e.wrap = m_wrap;
        exp_q.push_back(e);
        @(posedge clki);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk({tag, "_led"},  32'(led),  32'(got.led));
            chk({tag, "_tick"}, 32'(tick), 32'(got.tick));
            chk({tag, "_wrap"}, 32'(wrap), 32'(got.wrap));
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step_cycle(tag);
    endtask

    initial begin
        bit found;

        // reset state; en/mode/div are overridden by rs
        rs = 1'b0; en = 1'b1; mode = 2'b11; div = DW'(0);
        run("reset", 3);
        mode = 2'b00; div = DW'(3);

        // shift-left every 4 cycles, wrap on 80->01
        rs = 1'b1;
        run("shl", 40);

        // bounce, step every cycle
        mode = 2'b10; div = DW'(0);
        run("bounce", 32);

        // fill/drain
        mode = 2'b11;
        run("fill", 36);

        // switch shift-left -> shift-right mid-period at led=08
        mode = 2'b00; div = DW'(3);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step_cycle("t4_pre");
            found = (m_mode == 2'b00) && (m_k == 3) && (m_cnt == DW'(1));
        end
        chk("t4_sync", 32'(found), 32'd1);
        mode = 2'b01;
        run("t4_shr", 24);

        // large divide, then shrink below count, then freeze and resume
        mode = 2'b00; div = DW'(1000);
        run("t5_slow", 500);
        div = DW'(10);
        run("t5_fast", 30);
        en = 1'b0;
        run("t5_freeze", 20);
        en = 1'b1;
        run("t5_resume", 30);

        // reset during bounce, moving down at led=10
        mode = 2'b10; div = DW'(0);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step_cycle("t6_pre");
            found = (m_mode == 2'b10) && (m_k == 2 * N - 2 - 4);
        end
        chk("t6_sync", 32'(found), 32'd1);
        rs = 1'b0;
        run("t6_reset", 1);
        rs = 1'b1;
        run("t6_restart", 20);

        // random mode/div/en mix
        for (int blk = 0; blk < 25; blk++) begin
            mode = 2'($urandom_range(3, 0));
            div  = DW'($urandom_range(4, 0));
            en   = ($urandom_range(3, 0) != 0);
            run("rand", 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
